// File: rtl/instr_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch unit
// and instruction memory.
interface instr_fetch_if;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;

   modport master (
      output o_imem_req,
      output o_imem_addr,
      input  i_imem_ack,
      input  i_imem_rdata
   );

   modport slave (
      input  o_imem_req,
      input  o_imem_addr,
      output i_imem_ack,
      output i_imem_rdata
   );
endinterface

// File: rtl/instr_fetch.sv
// Fetch/PC sequencer for the unpipelined MIPS core: fetches one word,
// waits for the datapath to finish it, then resolves jump/branch/next PC.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   instr_fetch_if.master imem,
   output logic [31:0]   o_instr,
   output logic          o_instr_valid,
   input  logic          i_instr_done,
   input  logic          i_jump,
   input  logic          i_beq,
   input  logic          i_bne,
   input  logic          i_zero,
   output logic [31:0]   o_pc,
   output logic [31:0]   o_pc_plus4,
   output logic [31:0]   o_retired
);

   localparam logic [0:0]  S_FETCH = 1'b0;
   localparam logic [0:0]  S_EXEC  = 1'b1;
   localparam logic [31:0] PC0     = {RESET_PC[31:2], 2'b00};

   logic [0:0]  r_state;
   logic        r_req;
   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_retired;

   logic [31:0] w_plus4;
   logic [31:0] w_boff;
   logic [31:0] w_jtgt;
   logic [31:0] w_next;
   logic        w_taken;

   assign w_plus4 = r_pc + 32'd4;
   assign w_boff  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_jtgt  = {w_plus4[31:28], r_instr[25:0], 2'b00};
   assign w_taken = (i_beq & i_zero) | (i_bne & ~i_zero);

   always_comb begin
      w_next = w_plus4;
      if (i_jump == 1'b1)
         w_next = w_jtgt;
      else if (w_taken == 1'b1)
         w_next = w_plus4 + w_boff;
   end

   // req drops only on ack; it is re-raised on the done edge so a
   // zero-wait memory gives the minimum two cycles per instruction
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_FETCH;
         r_req     <= 1'b0;
         r_valid   <= 1'b0;
         r_pc      <= PC0;
         r_instr   <= 32'd0;
         r_retired <= 32'd0;
      end else begin
         r_valid <= 1'b0;
         if (r_state == S_FETCH) begin
            if (r_req && imem.i_imem_ack) begin
               r_instr <= imem.i_imem_rdata;
               r_valid <= 1'b1;
               r_req   <= 1'b0;
               r_state <= S_EXEC;
            end else begin
               r_req <= 1'b1;
            end
         end else begin
            if (i_instr_done) begin
               r_pc      <= w_next;
               r_retired <= r_retired + 32'd1;
               r_req     <= 1'b1;
               r_state   <= S_FETCH;
            end
         end
      end
   end

   assign imem.o_imem_req  = r_req;
   assign imem.o_imem_addr = r_pc;
   assign o_instr          = r_instr;
   assign o_instr_valid    = r_valid;
   assign o_pc             = r_pc;
   assign o_pc_plus4       = w_plus4;
   assign o_retired        = r_retired;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table of fetch/resolve steps
// plus hand sequences for reset, wait states and ignored strobes.
module tb_instr_fetch;

   typedef struct {
      logic [31:0] rdata;
      logic        jump;
      logic        beq;
      logic        bne;
      logic        zero;
      logic [31:0] exp_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        done = 1'b0;
   logic        jump = 1'b0;
   logic        beq = 1'b0;
   logic        bne = 1'b0;
   logic        zero = 1'b0;

   logic [31:0] instr1, pc1, pc4_1, ret1;
   logic        valid1;
   logic [31:0] instr2, pc2, pc4_2, ret2;
   logic        valid2;

   int checks = 0;
   int errors = 0;

   instr_fetch_if bus1();
   instr_fetch_if bus2();

   assign bus2.i_imem_ack   = bus1.i_imem_ack;
   assign bus2.i_imem_rdata = bus1.i_imem_rdata;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0040)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .imem          (bus1.master),
      .o_instr       (instr1),
      .o_instr_valid (valid1),
      .i_instr_done  (done),
      .i_jump        (jump),
      .i_beq         (beq),
      .i_bne         (bne),
      .i_zero        (zero),
      .o_pc          (pc1),
      .o_pc_plus4    (pc4_1),
      .o_retired     (ret1)
   );

   instr_fetch #(.RESET_PC(32'h3000_0013)) dut2 (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .imem          (bus2.master),
      .o_instr       (instr2),
      .o_instr_valid (valid2),
      .i_instr_done  (done),
      .i_jump        (jump),
      .i_beq         (beq),
      .i_bne         (bne),
      .i_zero        (zero),
      .o_pc          (pc2),
      .o_pc_plus4    (pc4_2),
      .o_retired     (ret2)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, " rst pc"}, pc1, 32'h40);
      chk({tag, " rst pc2"}, pc2, 32'h3000_0010);
      chk({tag, " rst req"}, {31'd0, bus1.o_imem_req}, 32'd0);
      chk({tag, " rst instr"}, instr1, 32'd0);
      chk({tag, " rst valid"}, {31'd0, valid1}, 32'd0);
      chk({tag, " rst retired"}, ret1, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk({tag, " req after rst"}, {31'd0, bus1.o_imem_req}, 32'd1);
      chk({tag, " addr after rst"}, bus1.o_imem_addr, 32'h40);
   endtask

   task automatic fetch_exec(input logic [31:0] rd, input logic j,
                             input logic b, input logic n,
                             input logic z);
      bus1.i_imem_ack   = 1'b1;
      bus1.i_imem_rdata = rd;
      step();
      bus1.i_imem_ack = 1'b0;
      done = 1'b1;
      jump = j;
      beq  = b;
      bne  = n;
      zero = z;
      step();
      done = 1'b0;
      jump = 1'b0;
      beq  = 1'b0;
      bne  = 1'b0;
      zero = 1'b0;
   endtask

   vec_t vt[13];

   initial begin
      int ret;
      vt[0]  = '{32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100};
      vt[1]  = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00FC};
      vt[2]  = '{32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100};
      vt[3]  = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0104};
      vt[4]  = '{32'h0800_0080, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200};
      vt[5]  = '{32'h1400_0003, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0210};
      vt[6]  = '{32'h0800_0080, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200};
      vt[7]  = '{32'h1400_0003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0204};
      vt[8]  = '{32'h1000_0003, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0214};
      vt[9]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0218};
      vt[10] = '{32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040};
      vt[11] = '{32'h1000_FFEE, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC};
      vt[12] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};

      bus1.i_imem_ack   = 1'b0;
      bus1.i_imem_rdata = 32'd0;
      #2;
      do_reset("init");

      // zero-wait fetch, one-cycle valid pulse
      bus1.i_imem_ack   = 1'b1;
      bus1.i_imem_rdata = 32'h2108_0001;
      step();
      chk("first instr", instr1, 32'h2108_0001);
      chk("first valid", {31'd0, valid1}, 32'd1);
      chk("req low in exec", {31'd0, bus1.o_imem_req}, 32'd0);
      bus1.i_imem_ack = 1'b0;
      step();
      chk("valid pulse ends", {31'd0, valid1}, 32'd0);
      chk("pc held in exec", pc1, 32'h40);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("seq pc 44", pc1, 32'h44);
      chk("retired 1", ret1, 32'd1);
      fetch_exec(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("seq pc 48", pc1, 32'h48);
      chk("retired 2", ret1, 32'd2);

      // three wait states with a spurious done while fetching
      done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("wait%0d addr", i), bus1.o_imem_addr, 32'h48);
         chk($sformatf("wait%0d req", i),
             {31'd0, bus1.o_imem_req}, 32'd1);
         chk($sformatf("wait%0d retired", i), ret1, 32'd2);
      end
      done = 1'b0;
      bus1.i_imem_ack   = 1'b1;
      bus1.i_imem_rdata = 32'h0000_0020;
      step();
      chk("wait ack valid", {31'd0, valid1}, 32'd1);
      chk("wait pc cycle4", pc1, 32'h48);
      bus1.i_imem_ack = 1'b0;
      done = 1'b1;
      step();
      done = 1'b0;
      chk("wait pc cycle5", pc1, 32'h4C);

      // spurious ack during exec
      bus1.i_imem_ack   = 1'b1;
      bus1.i_imem_rdata = 32'hAAAA_0001;
      step();
      bus1.i_imem_rdata = 32'h5555_0002;
      step();
      chk("spur ack instr", instr1, 32'hAAAA_0001);
      chk("spur ack valid", {31'd0, valid1}, 32'd0);
      chk("spur ack req", {31'd0, bus1.o_imem_req}, 32'd0);
      bus1.i_imem_ack = 1'b0;
      done = 1'b1;
      step();
      done = 1'b0;
      chk("after spur pc", pc1, 32'h50);

      // reset in the middle of a fetch wait, then mid-exec
      step();
      do_reset("mid-fetch");
      bus1.i_imem_ack   = 1'b1;
      bus1.i_imem_rdata = 32'h1234_5678;
      step();
      bus1.i_imem_ack = 1'b0;
      chk("pre-rst exec instr", instr1, 32'h1234_5678);
      do_reset("mid-exec");

      // vector table
      ret = 0;
      for (int i = 0; i < 13; i++) begin
         fetch_exec(vt[i].rdata, vt[i].jump, vt[i].beq,
                    vt[i].bne, vt[i].zero);
         ret++;
         chk($sformatf("vec%0d pc", i), pc1, vt[i].exp_pc);
         chk($sformatf("vec%0d pc+4", i), pc4_1, vt[i].exp_pc + 32'd4);
         chk($sformatf("vec%0d instr", i), instr1, vt[i].rdata);
         chk($sformatf("vec%0d retired", i), ret1, ret);
      end

      // jump has priority over a taken beq
      do_reset("jump-prio");
      fetch_exec(32'h0800_0100, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("prio pc hi", pc2, 32'h3000_0400);
      chk("prio pc lo", pc1, 32'h0000_0400);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch and PC sequencer for the unpipelined MIPS core. It owns the program counter and fetches 32-bit words from instruction memory over a req/ack handshake. It presents each word to the opcode decoder and datapath. It takes the decoder's jump/beq/bne strobes and the ALU zero flag back in, and uses them to compute the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] are ignored and treated as 0.

Ports:
i_clk  in  1  core clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
o_imem_req  out  1  instruction memory request, registered.
o_imem_addr  out  32  fetch address; always equals o_pc.
i_imem_ack  in  1  memory read done; i_imem_rdata is valid in the same cycle.
i_imem_rdata  in  32  fetched instruction word.
o_instr  out  32  current instruction; held until the next ack.
o_instr_valid  out  1  one-cycle pulse: o_instr has just been updated.
i_instr_done  in  1  datapath has finished the current instruction; resolve the next PC now.
i_jump  in  1  jump strobe from the decoder.
i_beq  in  1  beq strobe from the decoder.
i_bne  in  1  bne strobe from the decoder.
i_zero  in  1  ALU zero flag for the current instruction.
o_pc  out  32  address of the current/pending instruction.
o_pc_plus4  out  32  o_pc + 4, modulo 2^32.
o_retired  out  32  count of completed instructions.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=FETCH, o_pc={RESET_PC[31:2],2'b00}
  - o_imem_req=0, o_instr=0, o_instr_valid=0, o_retired=0
  - o_imem_req rises on the first clock edge after reset is released.
- FSM has two states, FETCH and EXEC.
- FETCH:
  - o_imem_req=1 and o_imem_addr=o_pc, held stable until ack.
  - On a cycle with i_imem_ack=1: o_instr<=i_imem_rdata, o_instr_valid<=1 for the next cycle only, o_imem_req<=0, state<=EXEC.
  - i_instr_done is ignored in FETCH.
- EXEC:
  - o_imem_req=0; i_imem_ack is ignored.
  - On a cycle with i_instr_done=1:
    - Sample i_jump, i_beq, i_bne and i_zero.
    - Update o_pc to the next PC.
    - o_retired increments by 1, wrapping at 2^32.
    - state<=FETCH.
  - i_instr_done is legal in the first EXEC cycle, i.e. the cycle in which o_instr_valid=1.
- Next PC, evaluated in priority order:
  - i_jump=1: {o_pc_plus4[31:28], o_instr[25:0], 2'b00}.
  - Else, if branch taken = (i_beq & i_zero) | (i_bne & ~i_zero): o_pc_plus4 + {{14{o_instr[15]}}, o_instr[15:0], 2'b00}, modulo 2^32.
  - Otherwise: o_pc_plus4.
- Only 1'b1 counts as asserted on the strobes. If beq and bne are both 1, the taken formula above still applies as written.
- Timing:
  - Minimum 2 cycles per instruction (zero-wait ack, done in the first EXEC cycle).
  - Each memory wait state adds 1 cycle.
  - o_pc changes only on the done edge.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000. The branch adder also wraps silently.
- Reset during FETCH or EXEC aborts the operation immediately with no partial update. The memory must not ack the aborted request after reset is released.
- o_pc_plus4 is combinational from o_pc. All other outputs are registered.

Test Plan:
- Reset with RESET_PC=32'h0000_0040:
  - o_pc=0x40, req=0 during reset.
  - req=1 with addr=0x40 on the first edge after release.
  - Zero-wait ack with rdata=0x2108_0001 gives o_instr=0x2108_0001, valid pulse for exactly 1 cycle.
- Sequential execution: done with all strobes=0 gives o_pc 0x40->0x44->0x48 and o_retired=2. Add 3 ack wait states and confirm addr stays stable and the instruction takes 5 cycles.
- beq: o_instr=0x1000_FFFE, o_pc=0x100.
  - beq=1, zero=1: next o_pc=0x0FC.
  - beq=1, zero=0: next o_pc=0x104.
- bne: o_instr=0x1400_0003, o_pc=0x200.
  - bne=1, zero=0: next o_pc=0x210.
  - bne=1, zero=1: next o_pc=0x204.
- Jump priority: o_pc=0x3000_0010, o_instr=0x0800_0100, jump=1 and beq=1 with zero=1 gives next o_pc=0x3000_0400.
- Edge cases:
  - o_pc=0xFFFF_FFFC, no branch or jump: next o_pc=0x0000_0000.
  - Assert i_rst_n=0 mid-wait in FETCH and mid-EXEC: outputs clear immediately, and fetch restarts at RESET_PC.
  - Spurious ack in EXEC and done in FETCH are both ignored.
